// File: rtl/chunked_seq_adder_if.sv
// Handshake and operand/result bundle for chunked_seq_adder.
// The sub select exists only when SUB_MODE_EN is defined.
interface chunked_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             carry_in;
`ifdef SUB_MODE_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, x, y, carry_in,
`ifdef SUB_MODE_EN
        output sub,
`endif
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, x, y, carry_in,
`ifdef SUB_MODE_EN
        input  sub,
`endif
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock through
// one narrow carry chain, with a start/busy/done handshake.
// WIDTH must be a positive multiple of CHUNK; N = WIDTH/CHUNK slice cycles.
// Optional feature macro: SUB_MODE_EN (adds the sub port; x - y via ~y + 1).
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    chunked_seq_adder_if.slave bus
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_slice;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             co_q;
    logic             ovf_q;
    logic [IDXW-1:0]  idx_q;

    logic [WIDTH-1:0] b_eff;
    logic             carry_init;
    logic [CHUNK:0]   slice_sum;

    // Effective B operand and initial carry, chosen at acceptance time
    always_comb begin
`ifdef SUB_MODE_EN
        b_eff      = bus.sub ? ~bus.y : bus.y;
        carry_init = bus.sub ? 1'b1 : bus.carry_in;
`else
        b_eff      = bus.y;
        carry_init = bus.carry_in;
`endif
    end

    assign last_slice = (idx_q == IDXW'(N - 1));
    assign slice_sum  = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
                      + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, carry_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start is only honoured in IDLE or DONE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_slice) state_nxt = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch and slice datapath; results hold until the next first slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= bus.x;
            b_q     <= b_eff;
            carry_q <= carry_init;
            idx_q   <= '0;
        end else if (state == RUN) begin
            sum_q[idx_q*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
            carry_q <= slice_sum[CHUNK];
            idx_q   <= idx_q + IDXW'(1);
            if (last_slice) begin
                co_q  <= slice_sum[CHUNK];
                // top bit of the final slice is sum[MSB]
                ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (slice_sum[CHUNK-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ovf_q;
endmodule
